// File: rtl/muldiv_if.sv
// muldiv_if: request/write-back bundle between the EX stage and muldiv_seq.
//   start_i/op_i/op1_i/op2_i/reg_waddr_i/flush_i : op request from the pipeline
//   stall_o/busy_o                                : pipeline hold and activity
//   reg_waddr_o/reg_we_o/reg_wdata_o              : one-beat write-back to exe_mem
// master = pipeline side, slave = muldiv_seq side.
interface muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start_i;
  logic [2:0]       op_i;
  logic [WIDTH-1:0] op1_i;
  logic [WIDTH-1:0] op2_i;
  logic [4:0]       reg_waddr_i;
  logic             flush_i;
  logic             stall_o;
  logic             busy_o;
  logic [4:0]       reg_waddr_o;
  logic             reg_we_o;
  logic [WIDTH-1:0] reg_wdata_o;

  modport master (
    output start_i, op_i, op1_i, op2_i, reg_waddr_i, flush_i,
    input  stall_o, busy_o, reg_waddr_o, reg_we_o, reg_wdata_o
  );

  modport slave (
    input  start_i, op_i, op1_i, op2_i, reg_waddr_i, flush_i,
    output stall_o, busy_o, reg_waddr_o, reg_we_o, reg_wdata_o
  );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide unit in EX.
// Ports: clk_i (clock), rst_i (sync active-high reset), bus (muldiv_if.slave):
//   request start_i/op_i/op1_i/op2_i/reg_waddr_i/flush_i, status stall_o/busy_o,
//   write-back reg_waddr_o/reg_we_o/reg_wdata_o (valid only in DONE).
// Optional macro MULDIV_FAST_MUL_EN: multiplies finish in one cycle via a
// 33x33 signed multiplier; divides stay iterative.
module muldiv_seq #(
  parameter int unsigned WIDTH   = 32,
  parameter bit          SKIP_X0 = 1'b1
) (
  input logic      clk_i,
  input logic      rst_i,
  muldiv_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned PW    = 2 * WIDTH;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_op;
  logic [4:0]       r_waddr;
  logic             r_we_en, r_special, r_sign1, r_sign2;
  logic [WIDTH-1:0] r_spec_res, r_mcand;
  logic [PW-1:0]    r_prod;   // mul: {hi,lo} product; div: {remainder, dividend/quotient}

  logic             w_accept, w_stall;
  logic             w_s1, w_s2, w_neg1, w_neg2;
  logic [WIDTH-1:0] w_abs1, w_abs2;
  logic             w_skip, w_div_zero, w_ovf, w_fast, w_special;
  logic [WIDTH-1:0] w_spec_res, w_result, w_q, w_r;
  logic [WIDTH:0]   w_sum, w_trial;
  logic [PW-1:0]    w_mul_next, w_div_next, w_p;

  // Operand sign handling: signed ops work on magnitudes plus sign flags
  assign w_s1   = (bus.op_i == OP_MULH) | (bus.op_i == OP_MULHSU) |
                  (bus.op_i == OP_DIV)  | (bus.op_i == OP_REM);
  assign w_s2   = (bus.op_i == OP_MULH) | (bus.op_i == OP_DIV) | (bus.op_i == OP_REM);
  assign w_neg1 = w_s1 & bus.op1_i[WIDTH-1];
  assign w_neg2 = w_s2 & bus.op2_i[WIDTH-1];
  assign w_abs1 = w_neg1 ? -bus.op1_i : bus.op1_i;
  assign w_abs2 = w_neg2 ? -bus.op2_i : bus.op2_i;

  // Cases resolved without iterating
  assign w_skip     = SKIP_X0 && (bus.reg_waddr_i == 5'd0);
  assign w_div_zero = bus.op_i[2] & (bus.op2_i == '0);
  assign w_ovf      = ((bus.op_i == OP_DIV) | (bus.op_i == OP_REM)) &
                      (bus.op1_i == {1'b1, {(WIDTH-1){1'b0}}}) & (bus.op2_i == '1);

`ifdef MULDIV_FAST_MUL_EN
  logic signed [WIDTH:0]    w_fa, w_fb;
  logic signed [PW+1:0]     w_fp;
  assign w_fa   = {w_s1 & bus.op1_i[WIDTH-1], bus.op1_i};
  assign w_fb   = {w_s2 & bus.op2_i[WIDTH-1], bus.op2_i};
  assign w_fp   = w_fa * w_fb;
  assign w_fast = ~bus.op_i[2];
`else
  assign w_fast = 1'b0;
`endif

  assign w_special = w_skip | w_div_zero | w_ovf | w_fast;

  always_comb begin
    w_spec_res = '0;
    if (w_div_zero)   w_spec_res = bus.op_i[1] ? bus.op1_i : '1;
    else if (w_ovf)   w_spec_res = bus.op_i[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
`ifdef MULDIV_FAST_MUL_EN
    else if (w_fast)  w_spec_res = (bus.op_i == OP_MUL) ? w_fp[WIDTH-1:0] : w_fp[PW-1:WIDTH];
`endif
  end

  // Shift-add multiply step: add multiplicand into the high half, shift right
  assign w_sum      = {1'b0, r_prod[PW-1:WIDTH]} + {1'b0, r_mcand};
  assign w_mul_next = r_prod[0] ? {w_sum, r_prod[WIDTH-1:1]} : {1'b0, r_prod[PW-1:1]};

  // Restoring divide step: trial-subtract divisor from {rem, next dividend bit}
  assign w_trial    = {r_prod[PW-1:WIDTH], r_prod[WIDTH-1]} - {1'b0, r_mcand};
  assign w_div_next = w_trial[WIDTH] ? {r_prod[PW-2:0], 1'b0}
                                     : {w_trial[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b1};

  // Sign correction of the iterative result
  assign w_p = (r_sign1 ^ r_sign2) ? -r_prod : r_prod;
  assign w_q = (r_sign1 ^ r_sign2) ? -r_prod[WIDTH-1:0] : r_prod[WIDTH-1:0];
  assign w_r = r_sign1 ? -r_prod[PW-1:WIDTH] : r_prod[PW-1:WIDTH];

  always_comb begin
    w_result = '0;
    if (r_special)            w_result = r_spec_res;
    else if (r_op == OP_MUL)  w_result = w_p[WIDTH-1:0];
    else if (!r_op[2])        w_result = w_p[PW-1:WIDTH];
    else if (!r_op[1])        w_result = w_q;
    else                      w_result = w_r;
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next state and status outputs
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_stall  = 1'b0;
    case (r_state)
      IDLE: if (bus.start_i && !bus.flush_i) begin
        w_accept = 1'b1;
        w_stall  = 1'b1;
        w_next   = w_special ? DONE : BUSY;
      end
      BUSY: begin
        w_stall = 1'b1;
        if (bus.flush_i)                          w_next = IDLE;
        else if (r_cnt == CNT_W'(WIDTH - 1))      w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand capture and iteration datapath
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt      <= '0;
      r_op       <= '0;
      r_waddr    <= '0;
      r_we_en    <= 1'b0;
      r_special  <= 1'b0;
      r_sign1    <= 1'b0;
      r_sign2    <= 1'b0;
      r_spec_res <= '0;
      r_mcand    <= '0;
      r_prod     <= '0;
    end else if (w_accept) begin
      r_cnt      <= '0;
      r_op       <= bus.op_i;
      r_waddr    <= bus.reg_waddr_i;
      r_we_en    <= ~w_skip;
      r_special  <= w_special;
      r_sign1    <= w_neg1;
      r_sign2    <= w_neg2;
      r_spec_res <= w_spec_res;
      r_mcand    <= bus.op_i[2] ? w_abs2 : w_abs1;
      r_prod     <= {{WIDTH{1'b0}}, (bus.op_i[2] ? w_abs1 : w_abs2)};
    end else if (r_state == BUSY) begin
      r_cnt  <= r_cnt + CNT_W'(1);
      r_prod <= r_op[2] ? w_div_next : w_mul_next;
    end
  end

  // Write-back beat only in DONE; a flush in DONE kills the write
  assign bus.stall_o     = w_stall;
  assign bus.busy_o      = (r_state != IDLE);
  assign bus.reg_we_o    = (r_state == DONE) & r_we_en & ~bus.flush_i;
  assign bus.reg_waddr_o = (r_state == DONE) ? r_waddr : 5'd0;
  assign bus.reg_wdata_o = (r_state == DONE) ? w_result : '0;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed vector table plus flush/reset/DONE-flush sequences.
module tb_muldiv_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(32)) bus ();

  muldiv_seq #(.WIDTH(32), .SKIP_X0(1'b1)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  wa;
    logic [31:0] exp;
    logic        we;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] wa, input logic [31:0] exp, input logic we,
                              input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.wa = wa; v.exp = exp; v.we = we;
    v.lat = lat;
`ifdef MULDIV_FAST_MUL_EN
    if (!op[2]) v.lat = 1;
`endif
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.start_i = 1'b0; bus.op_i = 3'd0; bus.op1_i = '0; bus.op2_i = '0;
    bus.reg_waddr_i = 5'd0; bus.flush_i = 1'b0;
  endtask

  // Issue one op, hold start while stalled, find DONE (busy & !stall) and check the beat
  task automatic run_op(input string nm, input vec_t v);
    int c, stalls;
    bit hit;
    @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = v.op; bus.op1_i = v.a; bus.op2_i = v.b;
    bus.reg_waddr_i = v.wa;
    c = 0; stalls = 0; hit = 1'b0;
    #1;
    while (c <= 40 && !hit) begin
      if (bus.busy_o && !bus.stall_o) hit = 1'b1;
      else begin
        if (bus.stall_o) stalls++;
        @(negedge clk); #1;
        c++;
      end
    end
    check({nm, " reached DONE"}, 32'(hit), 32'd1);
    if (hit) begin
      check({nm, " latency"}, 32'(c), 32'(v.lat));
      check({nm, " stall cycles"}, 32'(stalls), 32'(v.lat));
      check({nm, " we"}, 32'(bus.reg_we_o), 32'(v.we));
      check({nm, " waddr"}, 32'(bus.reg_waddr_o), 32'(v.wa));
      if (v.we) check({nm, " wdata"}, bus.reg_wdata_o, v.exp);
    end
    // start still high through DONE; it must not launch a new op
    @(negedge clk);
    bus.start_i = 1'b0;
    #1;
    check({nm, " idle after DONE"}, 32'(bus.busy_o), 32'd0);
    check({nm, " no beat after DONE"}, 32'(bus.reg_we_o), 32'd0);
  endtask

  initial begin
    bit saw_we;
    idle_inputs();

    // Reset state
    repeat (3) @(negedge clk);
    check("reset stall", 32'(bus.stall_o), 32'd0);
    check("reset busy", 32'(bus.busy_o), 32'd0);
    check("reset we", 32'(bus.reg_we_o), 32'd0);
    check("reset waddr", 32'(bus.reg_waddr_o), 32'd0);
    check("reset wdata", bus.reg_wdata_o, 32'd0);
    rst = 1'b0;

    vecs.push_back(mk(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 1'b1, 33));
    vecs.push_back(mk(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFF, 1'b1, 33));
    vecs.push_back(mk(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'h0000_0001, 1'b1, 33));
    vecs.push_back(mk(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE, 1'b1, 33));
    vecs.push_back(mk(3'd0, 32'hFFFF_FFFD, 32'd5,         5'd5, 32'hFFFF_FFF1, 1'b1, 33));
    vecs.push_back(mk(3'd1, 32'hFFFF_FFFD, 32'd5,         5'd6, 32'hFFFF_FFFF, 1'b1, 33));
    vecs.push_back(mk(3'd4, 32'hFFFF_FFF9, 32'd2,         5'd7, 32'hFFFF_FFFD, 1'b1, 33));
    vecs.push_back(mk(3'd6, 32'hFFFF_FFF9, 32'd2,         5'd8, 32'hFFFF_FFFF, 1'b1, 33));
    vecs.push_back(mk(3'd5, 32'd100,       32'd7,         5'd9, 32'd14,        1'b1, 33));
    vecs.push_back(mk(3'd7, 32'd100,       32'd7,         5'd10, 32'd2,        1'b1, 33));
    vecs.push_back(mk(3'd4, 32'd7,         32'hFFFF_FFFE, 5'd11, 32'hFFFF_FFFD, 1'b1, 33));
    vecs.push_back(mk(3'd6, 32'd7,         32'hFFFF_FFFE, 5'd12, 32'd1,        1'b1, 33));
    vecs.push_back(mk(3'd5, 32'hFFFF_FFFF, 32'd1,         5'd13, 32'hFFFF_FFFF, 1'b1, 33));
    vecs.push_back(mk(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0,        1'b1, 33));
    vecs.push_back(mk(3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1'b1, 33));
    vecs.push_back(mk(3'd5, 32'd5,         32'd0,         5'd16, 32'hFFFF_FFFF, 1'b1, 1));
    vecs.push_back(mk(3'd7, 32'd5,         32'd0,         5'd17, 32'd5,        1'b1, 1));
    vecs.push_back(mk(3'd4, 32'd5,         32'd0,         5'd18, 32'hFFFF_FFFF, 1'b1, 1));
    vecs.push_back(mk(3'd6, 32'h8000_0000, 32'd0,         5'd19, 32'h8000_0000, 1'b1, 1));
    vecs.push_back(mk(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'h8000_0000, 1'b1, 1));
    vecs.push_back(mk(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd21, 32'd0,        1'b1, 1));
    vecs.push_back(mk(3'd0, 32'd3,         32'd4,         5'd0,  32'd0,        1'b0, 1));
    vecs.push_back(mk(3'd5, 32'd100,       32'd7,         5'd0,  32'd0,        1'b0, 1));

    for (int i = 0; i < vecs.size(); i++) run_op($sformatf("v%0d", i), vecs[i]);

    // Flush at BUSY cycle 10: back to IDLE, no write beat ever
    @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = 3'd4; bus.op1_i = 32'd100; bus.op2_i = 32'd7;
    bus.reg_waddr_i = 5'd9;
    saw_we = 1'b0;
    repeat (10) begin
      @(negedge clk); #1;
      if (bus.reg_we_o) saw_we = 1'b1;
    end
    check("flush busy before", 32'(bus.busy_o), 32'd1);
    bus.flush_i = 1'b1; bus.start_i = 1'b0;
    @(negedge clk); #1;
    check("flush to idle", 32'(bus.busy_o), 32'd0);
    check("flush stall off", 32'(bus.stall_o), 32'd0);
    bus.flush_i = 1'b0;
    repeat (40) begin
      if (bus.reg_we_o) saw_we = 1'b1;
      @(negedge clk); #1;
    end
    check("flush no we", 32'(saw_we), 32'd0);
    run_op("mul after flush", mk(3'd0, 32'd3, 32'd4, 5'd22, 32'd12, 1'b1, 33));

    // Flush during DONE suppresses the beat in that same cycle
    @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = 3'd5; bus.op1_i = 32'd5; bus.op2_i = 32'd0;
    bus.reg_waddr_i = 5'd23;
    @(negedge clk); #1;
    check("done-flush in DONE", 32'(bus.busy_o && !bus.stall_o), 32'd1);
    check("done-flush we before", 32'(bus.reg_we_o), 32'd1);
    bus.flush_i = 1'b1;
    #1;
    check("done-flush we killed", 32'(bus.reg_we_o), 32'd0);
    @(negedge clk);
    bus.flush_i = 1'b0; bus.start_i = 1'b0;
    #1;
    check("done-flush idle", 32'(bus.busy_o), 32'd0);

    // Reset at BUSY cycle 5 clears everything on the next edge
    @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = 3'd4; bus.op1_i = 32'hFFFF_FFF9; bus.op2_i = 32'd2;
    bus.reg_waddr_i = 5'd24;
    repeat (5) @(negedge clk);
    #1;
    check("rst busy before", 32'(bus.busy_o), 32'd1);
    rst = 1'b1; bus.start_i = 1'b0;
    @(negedge clk); #1;
    check("rst busy", 32'(bus.busy_o), 32'd0);
    check("rst stall", 32'(bus.stall_o), 32'd0);
    check("rst we", 32'(bus.reg_we_o), 32'd0);
    check("rst waddr", 32'(bus.reg_waddr_o), 32'd0);
    check("rst wdata", bus.reg_wdata_o, 32'd0);
    rst = 1'b0;
    run_op("mul after rst", mk(3'd0, 32'd6, 32'd7, 5'd25, 32'd42, 1'b1, 33));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
